// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive and transmit cores.
//   uart_rx_state_t         : receiver FSM state encoding
//   UART_DEFAULT_BIT_CYCLES : clock cycles per bit (100 MHz clock, 560 ns bit)
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int UART_DEFAULT_BIT_CYCLES = 56;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_sync.sv
// ---------------------------------------------------------------------------
// uart_sync
// Two-flop synchronizer for a single asynchronous input.
//   clk : destination clock
//   rst : asynchronous active-low reset; both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronized output (two clk cycles of latency)
// ---------------------------------------------------------------------------
module uart_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [1:0] sync_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_reg <= {2{RESET_VAL}};
      end else begin
         sync_reg <= {sync_reg[0], d};
      end
   end

   assign q = sync_reg[1];

endmodule : uart_sync

// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART receiver, LSB first, mid-bit sampling from a cycle counter.
//   clk     : system clock, rising edge
//   rst     : asynchronous active-low reset
//   rx      : serial input, idle high, asynchronous to clk
//   rx_data : last correctly framed byte, held until the next good frame
//   po_flag : one-cycle strobe, rx_data valid in the same cycle
// ---------------------------------------------------------------------------
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int BIT_CYCLES  = UART_DEFAULT_BIT_CYCLES,
   parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       po_flag
);

   localparam int CW = $clog2(BIT_CYCLES);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);

   logic line;
   logic line_d_reg;
   logic fall;

   uart_rx_state_t state_reg, state_next;
   logic [CW-1:0]  cnt_reg, cnt_next;
   logic [2:0]     bit_idx_reg, bit_idx_next;
   logic [7:0]     shift_reg, shift_next;
   logic [7:0]     rx_data_reg, rx_data_next;
   logic           po_flag_reg, po_flag_next;

   uart_sync #(.RESET_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (line)
   );

   // Edge register after the synchronizer; idle-high reset avoids a false
   // falling edge when reset is released.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         line_d_reg <= 1'b1;
      end else begin
         line_d_reg <= line;
      end
   end

   assign fall = line_d_reg & ~line;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
         rx_data_reg <= '0;
         po_flag_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         bit_idx_reg <= bit_idx_next;
         shift_reg   <= shift_next;
         rx_data_reg <= rx_data_next;
         po_flag_reg <= po_flag_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      bit_idx_next = bit_idx_reg;
      shift_next   = shift_reg;
      rx_data_next = rx_data_reg;
      po_flag_next = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (fall) begin
               state_next = START;
               cnt_next   = '0;
            end
         end

         START: begin
            if (cnt_reg == HALF_LAST) begin
               cnt_next     = '0;
               bit_idx_next = '0;
               // A high line at mid-start means the edge was a glitch.
               state_next   = line ? IDLE : DATA;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         DATA: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next     = '0;
               shift_next   = {line, shift_reg[7:1]};
               bit_idx_next = bit_idx_reg + 1'b1;
               if (bit_idx_reg == 3'd7) begin
                  state_next = STOP;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         STOP: begin
            if (cnt_reg == BIT_LAST) begin
               cnt_next = '0;
               if (line) begin
                  // Leaving at mid-stop-bit leaves room for a back-to-back start.
                  rx_data_next = shift_reg;
                  po_flag_next = 1'b1;
                  state_next   = IDLE;
               end else begin
                  state_next   = WAIT_IDLE;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end

         WAIT_IDLE: begin
            // Hold off until the line recovers so a break is not re-read as starts.
            if (line) begin
               state_next = IDLE;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign rx_data = rx_data_reg;
   assign po_flag = po_flag_reg;

endmodule : uart_rx_core

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
// Directed bench for uart_rx_core at 100 MHz with a 56-cycle bit period.
// ---------------------------------------------------------------------------
module tb_uart_rx_core;

   localparam int BC = 56;

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] rx_data;
   logic       po_flag;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] got_q[$];
   int         wide_pulses = 0;
   logic       po_prev = 1'b0;

   uart_rx_core #(.BIT_CYCLES(BC)) dut (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx),
      .rx_data (rx_data),
      .po_flag (po_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record each received byte at the rising strobe; count strobes wider than 1 cycle.
   always @(negedge clk) begin
      if (po_flag === 1'b1 && po_prev !== 1'b1) got_q.push_back(rx_data);
      if (po_flag === 1'b1 && po_prev === 1'b1) wide_pulses++;
      po_prev = po_flag;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
      $display("check %-16s observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int bc, input logic stop_val);
      rx = 1'b0;
      wait_cyc(bc);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         wait_cyc(bc);
      end
      rx = stop_val;
      wait_cyc(bc);
      rx = 1'b1;
   endtask

   task automatic check_one(input string tag, input logic [7:0] exp);
      check({tag, "_count"}, got_q.size(), 1);
      if (got_q.size() > 0) check({tag, "_data"}, got_q[0], exp);
      else check({tag, "_data"}, 32'hFFFF_FFFF, exp);
      got_q.delete();
   endtask

   initial begin
      logic [7:0] b2b [4];
      logic [7:0] c5;
      b2b[0] = 8'h55; b2b[1] = 8'hA3; b2b[2] = 8'h00; b2b[3] = 8'hFF;
      c5 = 8'hC5;

      rst = 1'b0;
      rx  = 1'b1;
      wait_cyc(5);
      check("reset_rx_data", rx_data, 8'h00);
      check("reset_po_flag", po_flag, 1'b0);
      rst = 1'b1;
      wait_cyc(20);
      got_q.delete();

      // Four back-to-back frames
      for (int f = 0; f < 4; f++) send_byte(b2b[f], BC, 1'b1);
      wait_cyc(2 * BC);
      check("b2b_count", got_q.size(), 4);
      for (int f = 0; f < 4; f++) begin
         if (got_q.size() > f) check("b2b_data", got_q[f], b2b[f]);
         else check("b2b_data", 32'hFFFF_FFFF, b2b[f]);
      end
      got_q.delete();

      // 100 ns glitch then a good frame
      rx = 1'b0;
      #100;
      rx = 1'b1;
      wait_cyc(2 * BC);
      check("glitch_count", got_q.size(), 0);
      send_byte(8'h3C, BC, 1'b1);
      wait_cyc(2 * BC);
      check_one("after_glitch", 8'h3C);

      // Framing error: stop bit low
      send_byte(8'h81, BC, 1'b0);
      wait_cyc(2 * BC);
      check("frm_err_count", got_q.size(), 0);
      check("frm_err_hold", rx_data, 8'h3C);
      send_byte(8'h7E, BC, 1'b1);
      wait_cyc(2 * BC);
      check_one("after_frm_err", 8'h7E);

      // Break: 20 bit times low
      rx = 1'b0;
      wait_cyc(20 * BC);
      rx = 1'b1;
      wait_cyc(2 * BC);
      check("break_count", got_q.size(), 0);
      send_byte(8'h12, BC, 1'b1);
      wait_cyc(2 * BC);
      check_one("after_break", 8'h12);

      // Reset mid-frame after bit 3 of 8'hC5
      rx = 1'b0;
      wait_cyc(BC);
      for (int i = 0; i < 4; i++) begin
         rx = c5[i];
         wait_cyc(BC);
      end
      rst = 1'b0;
      #1;
      check("midrst_rx_data", rx_data, 8'h00);
      check("midrst_po_flag", po_flag, 1'b0);
      rx = 1'b1;
      wait_cyc(5);
      rst = 1'b1;
      wait_cyc(2 * BC);
      got_q.delete();
      send_byte(8'h5A, BC, 1'b1);
      wait_cyc(2 * BC);
      check_one("after_reset", 8'h5A);

      // Rate tolerance: 580 ns and 540 ns bits
      send_byte(8'h96, 58, 1'b1);
      wait_cyc(2 * BC);
      check_one("slow_580ns", 8'h96);
      send_byte(8'h96, 54, 1'b1);
      wait_cyc(2 * BC);
      check_one("fast_540ns", 8'h96);

      check("pulse_width", wide_pulses, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_uart_rx_core
